// File: rtl/slice_pkg.sv
// Shared types and default sizing for the slice packer.
package slice_pkg;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 16;
  localparam int TIMER_W   = 7;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/slice_packer_egg_timer.sv
// Idle timer: reloads to all ones, counts down, flags zero.
module egg_timer
  import slice_pkg::*;
#(
  parameter int TW = TIMER_W
) (
  input  logic sysclk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  logic [TW-1:0] cnt_q, cnt_d;

  // Stops at zero; the packer closes the frame there.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '1;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - TW'(1);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) cnt_q <= '1;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/slice_packer.sv
// Packs words into a frame, top slice first; closes on
// a full frame or when the idle timer expires.
module slice_packer
  import slice_pkg::*;
#(
  parameter int WORD_W    = slice_pkg::WORD_W,
  parameter int NUM_WORDS = slice_pkg::NUM_WORDS,
  parameter int TIMER_W   = slice_pkg::TIMER_W
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WORD_W*NUM_WORDS-1:0] out_data,
  output logic [4:0]                  out_count,
  output logic [WORD_W-1:0]           out_sum,
  output logic                        out_timeout,
  input  logic                        out_ready,
  output logic                        frame_pulse
);
  localparam int FW = WORD_W * NUM_WORDS;

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [FW-1:0]     buf_q, buf_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              tmo_q, tmo_d;
  logic              pulse_q, pulse_d;
  logic              t_load, t_dec, t_zero;
  logic              accept;

  assign accept = in_valid && (state_q == FILL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    sum_d   = sum_q;
    tmo_d   = tmo_q;
    pulse_d = 1'b0;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          buf_d[int'(idx_q)*WORD_W +: WORD_W] = in_data;
          sum_d  = sum_q + in_data;
          cnt_d  = cnt_q + 5'd1;
          idx_d  = idx_q - 5'd1;
          t_load = 1'b1;
          if (idx_q == 5'd0) begin
            state_d = HOLD;
            pulse_d = 1'b1;
          end
        end else if (cnt_q != 5'd0) begin
          if (t_zero) begin
            state_d = HOLD;
            tmo_d   = 1'b1;
            pulse_d = 1'b1;
          end else begin
            t_dec = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          idx_d   = 5'(NUM_WORDS - 1);
          cnt_d   = '0;
          buf_d   = '0;
          sum_d   = '0;
          tmo_d   = 1'b0;
          t_load  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= 5'(NUM_WORDS - 1);
      cnt_q   <= '0;
      buf_q   <= '0;
      sum_q   <= '0;
      tmo_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      pulse_q <= pulse_d;
    end
  end

  egg_timer #(
    .TW(TIMER_W)
  ) u_timer (
    .sysclk(sysclk),
    .reset (reset),
    .load  (t_load),
    .dec   (t_dec),
    .zero  (t_zero)
  );

  assign in_ready    = (state_q == FILL);
  assign out_valid   = (state_q == HOLD);
  assign out_data    = buf_q;
  assign out_count   = cnt_q;
  assign out_sum     = sum_q;
  assign out_timeout = tmo_q;
  assign frame_pulse = pulse_q;
endmodule

// File: tb/tb_slice_packer.sv
// Directed bench for slice_packer.
module tb_slice_packer;
  logic         sysclk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic         out_valid;
  logic [511:0] out_data;
  logic [4:0]   out_count;
  logic [31:0]  out_sum;
  logic         out_timeout;
  logic         out_ready;
  logic         frame_pulse;

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  slice_packer dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_sum    (out_sum),
    .out_timeout(out_timeout),
    .out_ready  (out_ready),
    .frame_pulse(frame_pulse)
  );

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
  endtask

  logic [511:0] exp_d;
  logic [511:0] snap;
  int           n;
  int           pulses;
  int           bad;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_pulse", 512'(frame_pulse), 512'(0));
    chk("rst_timeout", 512'(out_timeout), 512'(0));
    chk("rst_data", out_data, 512'(0));
    chk("rst_sum", 512'(out_sum), 512'(0));
    chk("rst_count", 512'(out_count), 512'(0));
    @(negedge sysclk);
    reset = 1'b0;
    tick();

    // Full frame 1..16
    exp_d = '0;
    bad   = 0;
    for (int i = 1; i <= 16; i++) begin
      exp_d[(16-i)*32 +: 32] = 32'(i);
      if (out_valid) bad++;
      push(32'(i));
    end
    chk("full_early_valid", 512'(bad), 512'(0));
    chk("full_valid", 512'(out_valid), 512'(1));
    chk("full_pulse", 512'(frame_pulse), 512'(1));
    chk("full_in_ready", 512'(in_ready), 512'(0));
    chk("full_count", 512'(out_count), 512'(16));
    chk("full_sum", 512'(out_sum), 512'(32'h88));
    chk("full_timeout", 512'(out_timeout), 512'(0));
    chk("full_slice15", 512'(out_data[480 +: 32]), 512'(1));
    chk("full_slice0", 512'(out_data[0 +: 32]), 512'(32'h10));
    chk("full_data", out_data, exp_d);

    // Backpressure, in_valid ignored in HOLD
    snap     = out_data;
    pulses   = 0;
    bad      = 0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (frame_pulse) pulses++;
      if (!out_valid || in_ready || out_data !== snap) bad++;
      if (out_count !== 5'd16 || out_sum !== 32'h88) bad++;
    end
    in_valid = 1'b0;
    chk("bp_extra_pulse", 512'(pulses), 512'(0));
    chk("bp_stable", 512'(bad), 512'(0));
    release_frame();
    chk("rel_valid", 512'(out_valid), 512'(0));
    chk("rel_in_ready", 512'(in_ready), 512'(1));
    chk("rel_sum", 512'(out_sum), 512'(0));
    chk("rel_count", 512'(out_count), 512'(0));
    chk("rel_data", out_data, 512'(0));

    // Idle timeout after three words
    push(32'hA);
    push(32'hB);
    push(32'hC);
    wait_valid(n);
    chk("tmo_cycles", 512'(n), 512'(128));
    exp_d = '0;
    exp_d[480 +: 32] = 32'hA;
    exp_d[448 +: 32] = 32'hB;
    exp_d[416 +: 32] = 32'hC;
    chk("tmo_pulse", 512'(frame_pulse), 512'(1));
    chk("tmo_timeout", 512'(out_timeout), 512'(1));
    chk("tmo_count", 512'(out_count), 512'(3));
    chk("tmo_sum", 512'(out_sum), 512'(32'h21));
    chk("tmo_data", out_data, exp_d);
    release_frame();
    chk("tmo_rel_timeout", 512'(out_timeout), 512'(0));

    // Word lands in the cycle the timer reads zero
    push(32'h5);
    for (int i = 0; i < 127; i++) tick();
    chk("sim_pre_valid", 512'(out_valid), 512'(0));
    push(32'h6);
    chk("sim_post_valid", 512'(out_valid), 512'(0));
    wait_valid(n);
    chk("sim_cycles", 512'(n), 512'(128));
    chk("sim_count", 512'(out_count), 512'(2));
    chk("sim_sum", 512'(out_sum), 512'(32'hB));
    chk("sim_timeout", 512'(out_timeout), 512'(1));
    release_frame();

    // Reset mid-frame
    for (int i = 0; i < 5; i++) push(32'h77 + 32'(i));
    reset = 1'b1;
    #2;
    chk("mrst_count", 512'(out_count), 512'(0));
    chk("mrst_sum", 512'(out_sum), 512'(0));
    chk("mrst_data", out_data, 512'(0));
    chk("mrst_in_ready", 512'(in_ready), 512'(1));
    tick();
    tick();
    @(negedge sysclk);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (frame_pulse || out_valid) pulses++;
    end
    chk("mrst_no_pulse", 512'(pulses), 512'(0));
    for (int i = 1; i <= 16; i++) push(32'h100 + 32'(i));
    chk("mrst_valid", 512'(out_valid), 512'(1));
    chk("mrst_frame_count", 512'(out_count), 512'(16));
    chk("mrst_frame_sum", 512'(out_sum), 512'(32'h1088));
    chk("mrst_slice15", 512'(out_data[480 +: 32]), 512'(32'h101));
    release_frame();

    // Sum wrap
    for (int i = 0; i < 16; i++) push(32'hFFFF_FFFF);
    chk("wrap_valid", 512'(out_valid), 512'(1));
    chk("wrap_sum", 512'(out_sum), 512'(32'hFFFF_FFF0));
    chk("wrap_count", 512'(out_count), 512'(16));
    chk("wrap_timeout", 512'(out_timeout), 512'(0));
    release_frame();
    chk("wrap_rel_valid", 512'(out_valid), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
